// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: 32-entry register file, one write port, single-entry output slot.
// Ports: issue (in_valid/in_ready, rs1/rs2/rd, imm, alu_src, func), writeback (wb_*),
//   slot (out_valid/out_ready, A, B, imm, alu_src, func, rd_addr); `OPERAND_BYPASS_EN enables forwarding.
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [1:0]      alu_src_in,
  input  logic [2:0]      func_in,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [XLEN-1:0] imm,
  output logic [1:0]      alu_src,
  output logic [2:0]      func,
  output logic [4:0]      rd_addr
);

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  state_t state_q;
  state_t state_d;

  logic            fire;
  logic            wb_we;
  logic [XLEN-1:0] a_rd;
  logic [XLEN-1:0] b_rd;
  logic [XLEN-1:0] rf [NREG];

`ifdef OPERAND_BYPASS_EN
  logic [4:0] rs1_q;
  logic [4:0] rs2_q;
  logic       hold;
`endif

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign fire      = in_valid && in_ready;
  assign wb_we     = wb_en && (wb_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (fire) state_d = FULL;
      FULL:  if (out_ready && !in_valid) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // x0 reads as zero regardless of array contents.
  always_comb begin
    a_rd = '0;
    b_rd = '0;
    if (rs1_addr != 5'd0) a_rd = rf[rs1_addr];
    if (rs2_addr != 5'd0) b_rd = rf[rs2_addr];
`ifdef OPERAND_BYPASS_EN
    if (wb_we && (wb_addr == rs1_addr)) a_rd = wb_data;
    if (wb_we && (wb_addr == rs2_addr)) b_rd = wb_data;
`endif
  end

`ifdef OPERAND_BYPASS_EN
  assign hold = out_valid && !out_ready;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      A       <= '0;
      B       <= '0;
      imm     <= '0;
      alu_src <= 2'b00;
      func    <= 3'b000;
      rd_addr <= 5'd0;
`ifdef OPERAND_BYPASS_EN
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
`endif
    end else begin
      if (wb_we) rf[wb_addr] <= wb_data;
      if (fire) begin
        A       <= a_rd;
        B       <= b_rd;
        imm     <= imm_in;
        alu_src <= alu_src_in;
        func    <= func_in;
        rd_addr <= rd_addr_in;
`ifdef OPERAND_BYPASS_EN
        rs1_q   <= rs1_addr;
        rs2_q   <= rs2_addr;
`endif
      end
`ifdef OPERAND_BYPASS_EN
      // A stalled slot tracks writebacks to its sources so it never goes stale.
      else if (hold && wb_we) begin
        if (wb_addr == rs1_q) A <= wb_data;
        if (wb_addr == rs2_q) B <= wb_data;
      end
`endif
    end
  end

endmodule
